// File: rtl/wb_stage_pipelined_if.sv
// Bundle between the MEM stage / hazard control and the write-back stage.
// Latency: none, pure signal grouping.
// Backpressure: carries stall/flush toward WB; the master drives them, the slave reacts.
interface wb_stage_pipelined_if #(
  parameter int DATA_W     = 16,
  parameter int BYTE_SEL_W = 1,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  // Control from hazard logic
  logic                  stall;
  logic                  flush;
  // MEM-stage instruction fields
  logic                  in_valid;
  logic                  in_reg_write;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [1:0]            in_wb_sel;
  logic                  in_mem_byte;
  logic                  in_mem_signed;
  logic [BYTE_SEL_W-1:0] in_byte_sel;
  logic [DATA_W-1:0]     in_alu_result;
  logic [DATA_W-1:0]     in_read_data_mem;
  logic [DATA_W-1:0]     in_link_pc;
  logic [DATA_W-1:0]     in_imm;
  // Register-file write port, forwarding path, retire counter
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0]     rf_wdata;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]     fwd_data;
  logic [CNT_W-1:0]      retire_count;

  modport master (
    output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel,
           in_mem_byte, in_mem_signed, in_byte_sel, in_alu_result,
           in_read_data_mem, in_link_pc, in_imm,
    input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, retire_count
  );

  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel,
           in_mem_byte, in_mem_signed, in_byte_sel, in_alu_result,
           in_read_data_mem, in_link_pc, in_imm,
    output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data, retire_count
  );
endinterface

// File: rtl/wb_stage_pipelined.sv
// Write-back stage: MEM/WB latch, 4-way result mux with byte-load extraction, RF write, WB->EX forward, retire count.
// Latency: fields captured at edge N drive result/forward after N; the register write commits at edge N+1.
// Backpressure: stall holds the latch and gates rf_we/retirement (forward stays live); flush drops the latch, even under stall.
module wb_stage_pipelined #(
  parameter int DATA_W     = 16,  // must equal 8 * 2**BYTE_SEL_W
  parameter int BYTE_SEL_W = 1,
  parameter int REG_ADDR_W = 3,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rst,
  wb_stage_pipelined_if.slave bus
);
  localparam int NUM_LANES = 1 << BYTE_SEL_W;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [1:0]            wb_sel;
    logic                  mem_byte;
    logic                  mem_signed;
    logic [BYTE_SEL_W-1:0] byte_sel;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     mem;
    logic [DATA_W-1:0]     link;
    logic [DATA_W-1:0]     imm;
  } wb_latch_t;

  wb_latch_t         w_next;
  wb_latch_t         r_latch;
  logic [7:0]        w_byte;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_result;
  logic              w_rd_is_zero_reg;
  logic              w_wr_ok;
  logic              w_retire;
  logic [CNT_W-1:0]  r_retire_count;

  // Pack the incoming MEM-stage fields into one latch word
  always_comb begin
    w_next            = '0;
    w_next.valid      = bus.in_valid;
    w_next.reg_write  = bus.in_reg_write;
    w_next.rd         = bus.in_rd;
    w_next.wb_sel     = bus.in_wb_sel;
    w_next.mem_byte   = bus.in_mem_byte;
    w_next.mem_signed = bus.in_mem_signed;
    w_next.byte_sel   = bus.in_byte_sel;
    w_next.alu        = bus.in_alu_result;
    w_next.mem        = bus.in_read_data_mem;
    w_next.link       = bus.in_link_pc;
    w_next.imm        = bus.in_imm;
  end

  // MEM/WB latch: flush beats stall, stall holds, otherwise capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch <= '0;
    end else if (bus.flush) begin
      // only valid matters for a bubble; the payload is left as is
      r_latch.valid <= 1'b0;
    end else if (!bus.stall) begin
      r_latch <= w_next;
    end
  end

  // Select the addressed byte lane of the memory word
  always_comb begin
    w_byte = r_latch.mem[7:0];
    for (int i = 0; i < NUM_LANES; i++) begin
      if (r_latch.byte_sel == i[BYTE_SEL_W-1:0]) begin
        w_byte = r_latch.mem[i*8 +: 8];
      end
    end
  end

  // Memory result: full word or sign/zero-extended byte
  always_comb begin
    if (r_latch.mem_byte) begin
      w_load = {{(DATA_W-8){w_byte[7] & r_latch.mem_signed}}, w_byte};
    end else begin
      w_load = r_latch.mem;
    end
  end

  // Result source mux, driven from latched fields only
  always_comb begin
    case (r_latch.wb_sel)
      SEL_ALU:  w_result = r_latch.alu;
      SEL_MEM:  w_result = w_load;
      SEL_LINK: w_result = r_latch.link;
      default:  w_result = r_latch.imm;
    endcase
  end

  assign w_rd_is_zero_reg = (ZERO_REG != 0) && (r_latch.rd == '0);
  assign w_wr_ok          = r_latch.valid & r_latch.reg_write & ~w_rd_is_zero_reg;
  // A stalled instruction is written once, in the cycle the stall drops
  assign w_retire         = r_latch.valid & ~bus.stall;

  // Retired-instruction counter, wraps naturally at 2**CNT_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_count <= '0;
    end else if (w_retire) begin
      r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.rf_we        = w_wr_ok & ~bus.stall;
  assign bus.rf_waddr     = r_latch.rd;
  assign bus.rf_wdata     = w_result;
  // Forwarding is not stall-gated so EX can keep consuming the held value
  assign bus.fwd_valid    = w_wr_ok;
  assign bus.fwd_rd       = r_latch.rd;
  assign bus.fwd_data     = w_result;
  assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined with a write scoreboard.
// Latency: expected writes are queued at issue and popped by a negedge monitor whenever rf_we is high.
// Backpressure: stall/flush sequences are driven directly; unexpected writes are flagged by the monitor.
module tb_wb_stage_pipelined;
  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  rd;
    logic [15:0] data;
  } wr_exp_t;

  wr_exp_t sb[$];

  wb_stage_pipelined_if #(
    .DATA_W(16), .BYTE_SEL_W(1), .REG_ADDR_W(3), .CNT_W(4)
  ) wb_bus ();

  wb_stage_pipelined #(
    .DATA_W(16), .BYTE_SEL_W(1), .REG_ADDR_W(3), .ZERO_REG(1), .CNT_W(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (wb_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input int n);
    wb_bus.in_valid     = 1'b0;
    wb_bus.in_reg_write = 1'b0;
    repeat (n) step();
  endtask

  // Drive one valid instruction for one cycle; queue its write if one is expected
  task automatic issue(input logic rw, input logic [2:0] rd, input logic [1:0] sel,
                       input logic mb, input logic ms, input logic bs,
                       input logic [15:0] alu, input logic [15:0] mem,
                       input logic [15:0] link, input logic [15:0] imm,
                       input logic expect_wr, input logic [15:0] exp_data);
    wb_bus.in_valid         = 1'b1;
    wb_bus.in_reg_write     = rw;
    wb_bus.in_rd            = rd;
    wb_bus.in_wb_sel        = sel;
    wb_bus.in_mem_byte      = mb;
    wb_bus.in_mem_signed    = ms;
    wb_bus.in_byte_sel      = bs;
    wb_bus.in_alu_result    = alu;
    wb_bus.in_read_data_mem = mem;
    wb_bus.in_link_pc       = link;
    wb_bus.in_imm           = imm;
    if (expect_wr) sb.push_back({rd, exp_data});
    step();
  endtask

  // Monitor: every register write must match the head of the scoreboard
  always @(negedge clk) begin
    wr_exp_t e;
    if (!rst && wb_bus.rf_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: rd=%0d data=0x%0h, no write expected",
                 wb_bus.rf_waddr, wb_bus.rf_wdata);
      end else begin
        e = sb.pop_front();
        if (wb_bus.rf_waddr !== e.rd || wb_bus.rf_wdata !== e.data ||
            wb_bus.fwd_valid !== 1'b1 || wb_bus.fwd_data !== e.data) begin
          errors++;
          $display("FAIL write: got rd=%0d data=0x%0h fwd_v=%0b fwd=0x%0h expected rd=%0d data=0x%0h",
                   wb_bus.rf_waddr, wb_bus.rf_wdata, wb_bus.fwd_valid, wb_bus.fwd_data,
                   e.rd, e.data);
        end
      end
    end
  end

  initial begin
    rst                     = 1'b1;
    wb_bus.stall            = 1'b0;
    wb_bus.flush            = 1'b0;
    wb_bus.in_valid         = 1'b0;
    wb_bus.in_reg_write     = 1'b0;
    wb_bus.in_rd            = '0;
    wb_bus.in_wb_sel        = '0;
    wb_bus.in_mem_byte      = 1'b0;
    wb_bus.in_mem_signed    = 1'b0;
    wb_bus.in_byte_sel      = '0;
    wb_bus.in_alu_result    = '0;
    wb_bus.in_read_data_mem = '0;
    wb_bus.in_link_pc       = '0;
    wb_bus.in_imm           = '0;

    // Reset state
    #1;
    chk("reset_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
    chk("reset_fwd_valid", {31'd0, wb_bus.fwd_valid}, 32'd0);
    chk("reset_wdata", {16'd0, wb_bus.rf_wdata}, 32'd0);
    chk("reset_count", {28'd0, wb_bus.retire_count}, 32'd0);
    #1 rst = 1'b0;
    step();
    bubble(2);
    chk("idle_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
    chk("idle_count", {28'd0, wb_bus.retire_count}, 32'd0);

    // Source select, rd=3
    issue(1, 3'd3, 2'b00, 0, 0, 0, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0, 1, 16'h1234);
    issue(1, 3'd3, 2'b01, 0, 0, 0, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0, 1, 16'hABCD);
    issue(1, 3'd3, 2'b10, 0, 0, 0, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0, 1, 16'h0042);
    issue(1, 3'd3, 2'b11, 0, 0, 0, 16'h1234, 16'hABCD, 16'h0042, 16'hFFF0, 1, 16'hFFF0);
    bubble(2);
    chk("count_after_sel", {28'd0, wb_bus.retire_count}, 32'd4);

    // Byte loads from 0x80F7, plus byte flags ignored on the immediate source
    issue(1, 3'd1, 2'b01, 1, 1, 0, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 1, 16'hFFF7);
    issue(1, 3'd1, 2'b01, 1, 0, 0, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 1, 16'h00F7);
    issue(1, 3'd1, 2'b01, 1, 1, 1, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 1, 16'hFF80);
    issue(1, 3'd1, 2'b01, 1, 0, 1, 16'h0000, 16'h80F7, 16'h0000, 16'h0000, 1, 16'h0080);
    issue(1, 3'd2, 2'b11, 1, 1, 1, 16'h0000, 16'h80F7, 16'h0000, 16'h9357, 1, 16'h9357);
    bubble(2);
    chk("count_after_byte", {28'd0, wb_bus.retire_count}, 32'd9);

    // Zero register suppressed; valid non-writing instruction still retires
    issue(1, 3'd0, 2'b00, 0, 0, 0, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    chk("zero_reg_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
    chk("zero_reg_fwd_valid", {31'd0, wb_bus.fwd_valid}, 32'd0);
    issue(0, 3'd2, 2'b00, 0, 0, 0, 16'h6666, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    chk("no_rw_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
    bubble(2);
    chk("count_after_zero", {28'd0, wb_bus.retire_count}, 32'd11);

    // Stall for 3 cycles: forward stays live, single write on release
    issue(1, 3'd5, 2'b11, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0007, 1, 16'h0007);
    wb_bus.in_valid     = 1'b0;
    wb_bus.in_reg_write = 1'b0;
    wb_bus.stall        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_fwd_valid", {31'd0, wb_bus.fwd_valid}, 32'd1);
      chk("stall_fwd_rd", {29'd0, wb_bus.fwd_rd}, 32'd5);
      chk("stall_fwd_data", {16'd0, wb_bus.fwd_data}, 32'h0007);
      chk("stall_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
      step();
    end
    wb_bus.stall = 1'b0;
    #1;
    chk("release_rf_we", {31'd0, wb_bus.rf_we}, 32'd1);
    step();
    chk("after_release_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
    bubble(2);
    chk("count_after_stall", {28'd0, wb_bus.retire_count}, 32'd12);

    // Flush during stall drops the instruction
    issue(1, 3'd6, 2'b00, 0, 0, 0, 16'h0BAD, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    wb_bus.in_valid     = 1'b0;
    wb_bus.in_reg_write = 1'b0;
    wb_bus.stall        = 1'b1;
    #1;
    chk("flush_pre_fwd_valid", {31'd0, wb_bus.fwd_valid}, 32'd1);
    wb_bus.flush = 1'b1;
    step();
    wb_bus.flush = 1'b0;
    wb_bus.stall = 1'b0;
    #1;
    chk("flush_fwd_valid", {31'd0, wb_bus.fwd_valid}, 32'd0);
    chk("flush_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
    bubble(2);
    chk("count_after_flush", {28'd0, wb_bus.retire_count}, 32'd12);

    // Back-to-back writes to the same register, in order
    issue(1, 3'd4, 2'b00, 0, 0, 0, 16'h1111, 16'h0000, 16'h0000, 16'h0000, 1, 16'h1111);
    issue(1, 3'd4, 2'b00, 0, 0, 0, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 1, 16'h2222);
    bubble(2);
    chk("count_after_b2b", {28'd0, wb_bus.retire_count}, 32'd14);

    // Three more reach 17 retirements; a 4-bit counter reads 1
    issue(1, 3'd7, 2'b10, 0, 0, 0, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 1, 16'h0100);
    issue(1, 3'd7, 2'b10, 0, 0, 0, 16'h0000, 16'h0000, 16'h0101, 16'h0000, 1, 16'h0101);
    issue(1, 3'd7, 2'b10, 0, 0, 0, 16'h0000, 16'h0000, 16'h0102, 16'h0000, 1, 16'h0102);
    bubble(2);
    chk("count_wrap", {28'd0, wb_bus.retire_count}, 32'd1);

    // Async reset mid-stall with a valid instruction in the latch
    issue(1, 3'd7, 2'b00, 0, 0, 0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    wb_bus.in_valid     = 1'b0;
    wb_bus.in_reg_write = 1'b0;
    wb_bus.stall        = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_fwd_valid", {31'd0, wb_bus.fwd_valid}, 32'd0);
    chk("arst_rf_waddr", {29'd0, wb_bus.rf_waddr}, 32'd0);
    chk("arst_rf_wdata", {16'd0, wb_bus.rf_wdata}, 32'd0);
    chk("arst_count", {28'd0, wb_bus.retire_count}, 32'd0);
    #2;
    rst          = 1'b0;
    wb_bus.stall = 1'b0;
    bubble(3);
    chk("post_arst_rf_we", {31'd0, wb_bus.rf_we}, 32'd0);
    chk("post_arst_count", {28'd0, wb_bus.retire_count}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipelined.md
Name: wb_stage_pipelined

Overview:
- Parametrised, registered write-back stage for the 16-bit RISC pipeline.
- Owns the MEM/WB pipeline latch and selects among four result sources: ALU, memory, link PC, immediate.
- Performs byte-load lane extraction with sign/zero extension.
- Drives the register-file write port and the WB→EX forwarding path, and counts retired instructions.

Parameters:
- DATA_W, 16: datapath width; must equal 8*2^BYTE_SEL_W.
- BYTE_SEL_W, 1: byte-lane select width. Default gives 2 lanes.
- REG_ADDR_W, 3: register address width (8 registers).
- ZERO_REG, 1: when 1, writes to register 0 are suppressed.
- CNT_W, 16: retire counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold MEM/WB latch contents; block retirement.
- flush  in  1  load a bubble into the latch.
- in_valid  in  1  MEM-stage instruction valid.
- in_reg_write  in  1  instruction writes a register.
- in_rd  in  REG_ADDR_W  destination register.
- in_wb_sel  in  2  result source: 00 ALU, 01 memory, 10 link PC, 11 immediate.
- in_mem_byte  in  1  0 = full-word load, 1 = byte load.
- in_mem_signed  in  1  byte load sign-extends when 1, zero-extends when 0.
- in_byte_sel  in  BYTE_SEL_W  byte lane for byte loads; lane 0 = bits [7:0].
- in_alu_result  in  DATA_W  ALU result.
- in_read_data_mem  in  DATA_W  memory read data.
- in_link_pc  in  DATA_W  return address.
- in_imm  in  DATA_W  immediate value.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_ADDR_W  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- fwd_valid  out  1  forwarding entry valid.
- fwd_rd  out  REG_ADDR_W  forwarding destination register.
- fwd_data  out  DATA_W  forwarding data.
- retire_count  out  CNT_W  retired-instruction count.

Behaviour:
- Latch, on rising clk, in priority order:
  - flush=1: valid_q←0. Other fields are don't-care. Flush overrides stall.
  - else stall=1: all latch fields hold.
  - else: all in_* fields captured; valid_q←in_valid.
- Reset (async, rst=1): valid_q=0, all latch fields 0, retire_count=0. Consequently rf_we=0, fwd_valid=0, rf_waddr=0, rf_wdata=0, fwd_rd=0, fwd_data=0 immediately, without waiting for clk. Reset mid-stall or mid-flush: reset wins; the latched instruction is lost and never written.
- Result mux is combinational from latched fields only. Latency: an instruction captured at edge N drives rf_wdata after edge N, and the register write commits at edge N+1.
- Source 01 (memory):
  - mem_byte_q=0: full word.
  - mem_byte_q=1: lane byte_sel_q extracted to bits [7:0]. Upper DATA_W-8 bits are copies of byte bit 7 when mem_signed_q=1, else 0.
- mem_byte_q and mem_signed_q are ignored for sources 00, 10 and 11.
- rf_waddr = rd_q; rf_wdata = muxed result.
- wr_ok = valid_q & reg_write_q & !(ZERO_REG & rd_q==0).
- rf_we = wr_ok & !stall. A stalled instruction writes exactly once: in the cycle stall deasserts.
- fwd_valid = wr_ok; not gated by stall, so forwarding stays available during a stall. fwd_rd = rd_q; fwd_data = rf_wdata.
- retire_count increments by 1 at each rising edge where valid_q=1 and stall=0. It counts valid instructions regardless of reg_write. It wraps from 2^CNT_W-1 to 0.
- Flush while stall=1 with valid_q=1: the instruction is dropped, not retired, and not written. rf_we is already 0 in that cycle because of the stall.
- Back-to-back instructions writing the same rd: each is written in order, one per cycle.

Test Plan:
- Reset: assert rst asynchronously between edges with valid_q=1 → rf_we=0, fwd_valid=0, retire_count=0 immediately; after release with no input, outputs stay 0.
- Source select: ALU=0x1234, mem=0xABCD, link=0x0042, imm=0xFFF0, rd=3, sel stepped 00/01/10/11 on four consecutive cycles → rf_wdata 0x1234, 0xABCD, 0x0042, 0xFFF0 on successive cycles; rf_we=1 each cycle; retire_count=4.
- Byte loads, mem=0x80F7:
  - lane0 signed → 0xFFF7
  - lane0 unsigned → 0x00F7
  - lane1 signed → 0xFF80
  - lane1 unsigned → 0x0080
- Zero register: rd=0, reg_write=1, ZERO_REG=1 → rf_we=0, fwd_valid=0, retire_count still increments.
- Stall/flush:
  - Instruction rd=5, data 0x0007, stall held 3 cycles → fwd_valid=1 for all 3 cycles, rf_we=0; a single rf_we pulse on release; retire_count +1 once.
  - Separately, flush during stall → no write, no increment.
- Counter wrap: CNT_W=4, 17 valid unstalled instructions → retire_count reads 1.
